dcache_responder: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that answers the memory-stage load/store requests produced by the execute stage. It returns load data, absorbs stores, and raises the memory-stage stall while a line is written back or refilled from main memory. It sits between the memory pipeline stage and a word-wide main-memory port, and it is the sole driver of the memory-stage stall.

---
 rtl/dcache_responder.sv | 140 ++++++++++++++
 tb/tb_dcache_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache for the memory stage.
// Hits complete combinationally; misses stall while the victim is written back and the line refilled.
module dcache_responder #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        read_en_i,
  input  logic        write_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);
  localparam int SETS      = 2**INDEX_BITS;
  localparam int WORDS     = 2**OFFSET_BITS;
  localparam int LINE_BITS = INDEX_BITS + OFFSET_BITS;
  localparam int TAG_BITS  = 30 - LINE_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;

  state_e                 state_q;
  logic [OFFSET_BITS-1:0] cnt_q;
  logic [OFFSET_BITS-1:0] cnt_d;
  logic [INDEX_BITS-1:0]  miss_index_q;
  logic [TAG_BITS-1:0]    miss_tag_q;
  logic [TAG_BITS-1:0]    victim_tag_q;
  logic [SETS-1:0]        valid_q;
  logic [SETS-1:0]        dirty_q;
  logic [TAG_BITS-1:0]    tag_q  [SETS];
  logic [31:0]            data_q [SETS*WORDS];

  logic [OFFSET_BITS-1:0] req_offset;
  logic [INDEX_BITS-1:0]  req_index;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   req;
  logic                   hit;
  logic                   miss;
  logic                   last_word;
  logic                   unused_addr_bits;

  assign req_offset       = addr_i[OFFSET_BITS+1:2];
  assign req_index        = addr_i[LINE_BITS+1:OFFSET_BITS+2];
  assign req_tag          = addr_i[31:LINE_BITS+2];
  assign unused_addr_bits = ^addr_i[1:0];

  assign req       = read_en_i | write_en_i;
  assign hit       = req && valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign miss      = (state_q == IDLE) && req && !hit;
  assign last_word = (cnt_q == {OFFSET_BITS{1'b1}});
  assign cnt_d     = cnt_q + 1'b1;

  // Memory-side outputs depend only on registered state, so they move on edges or reset.
  always_comb begin
    stall_o     = 1'b1;
    read_data_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        stall_o = req && !hit;
        if (hit) read_data_o = data_q[{req_index, req_offset}];
      end
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {victim_tag_q, miss_index_q, cnt_q, 2'b00};
        mem_wdata_o = data_q[{miss_index_q, cnt_q}];
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_tag_q, miss_index_q, cnt_q, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_index_q <= '0;
      miss_tag_q   <= '0;
      victim_tag_q <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            miss_index_q <= req_index;
            miss_tag_q   <= req_tag;
            victim_tag_q <= tag_q[req_index];
            cnt_q        <= '0;
            state_q      <= (valid_q[req_index] && dirty_q[req_index]) ? WRITEBACK : REFILL;
          end else if (hit && write_en_i) begin
            dirty_q[req_index] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ready_i) begin
            cnt_q <= cnt_d;
            if (last_word) state_q <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ready_i) begin
            cnt_q <= cnt_d;
            if (last_word) begin
              valid_q[miss_index_q] <= 1'b1;
              dirty_q[miss_index_q] <= 1'b0;
              state_q               <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && hit && write_en_i) begin
      data_q[{req_index, req_offset}] <= write_data_i;
    end
    if (state_q == REFILL && mem_ready_i) begin
      data_q[{miss_index_q, cnt_q}] <= mem_rdata_i;
      if (last_word) tag_q[miss_index_q] <= miss_tag_q;
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed and random accesses against an architectural memory model
// plus a resident-line model that predicts hits, write-backs and stall lengths.
module tb_dcache_responder;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        read_en_i, write_en_i;
  logic [31:0] addr_i, write_data_i;
  logic [31:0] read_data_o;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_ready_i;

  dcache_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .read_en_i(read_en_i), .write_en_i(write_en_i),
    .addr_i(addr_i), .write_data_i(write_data_i), .read_data_o(read_data_o),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } xfer_t;

  int checks   = 0;
  int failures = 0;
  int period   = 1;
  int req_cycles = 0;
  xfer_t seen_q[$];
  xfer_t exp_q[$];
  bit [31:0] mainmem [bit [31:0]];
  bit [31:0] golden  [bit [31:0]];
  bit [31:0] res_line [16];
  bit        res_valid [16];
  bit        res_dirty [16];

  function automatic logic [31:0] mval(input logic [31:0] a);
    return mainmem.exists(a) ? mainmem[a] : a;
  endfunction

  function automatic logic [31:0] gval(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory responder for one clock: word k of a transfer completes after period*k request cycles.
  task automatic cycle();
    bit rdy;
    if (mem_req_o) begin
      req_cycles++;
      rdy = (req_cycles % period) == 0;
    end else begin
      rdy = 1'($urandom_range(0, 1));
    end
    mem_ready_i = rdy;
    mem_rdata_i = (mem_req_o && !mem_we_o) ? mval(mem_addr_o) : 32'h0;
    if (rdy && mem_req_o) begin
      seen_q.push_back('{mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : mem_rdata_i});
      if (mem_we_o) mainmem[mem_addr_o] = mem_wdata_o;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic access(input bit wr, input bit both, input logic [31:0] addr,
                        input logic [31:0] wdata, input int per, input string tag);
    logic [31:0] word, line, a;
    int set, stalls, exp_stall;
    bit hit, dirty;
    word  = addr & 32'hFFFF_FFFC;
    line  = word >> 4;
    set   = int'(line[3:0]);
    hit   = res_valid[set] && (res_line[set] == line);
    dirty = res_valid[set] && res_dirty[set];
    exp_q.delete();
    seen_q.delete();
    if (!hit) begin
      if (dirty) begin
        for (int w = 0; w < 4; w++) begin
          a = {res_line[set][27:0], 4'b0000} | (32'(w) << 2);
          exp_q.push_back('{1'b1, a, gval(a)});
        end
      end
      for (int w = 0; w < 4; w++) begin
        a = {line[27:0], 4'b0000} | (32'(w) << 2);
        exp_q.push_back('{1'b0, a, 32'h0});
      end
    end
    exp_stall  = hit ? 0 : 1 + per * (dirty ? 8 : 4);
    period     = per;
    req_cycles = 0;
    read_en_i    = !wr || both;
    write_en_i   = wr;
    addr_i       = addr;
    write_data_i = wdata;
    #1;
    stalls = 0;
    while (stall_o === 1'b1 && stalls < 200) begin
      stalls++;
      cycle();
    end
    check({tag, " stall_cycles"}, stalls, exp_stall);
    check({tag, " mem_req_at_complete"}, 32'(mem_req_o), 32'h0);
    if (!wr) check({tag, " read_data"}, read_data_o, gval(word));
    check({tag, " xfer_count"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      check({tag, " xfer_we"}, 32'(seen_q[i].we), 32'(exp_q[i].we));
      check({tag, " xfer_addr"}, seen_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check({tag, " wb_data"}, seen_q[i].data, exp_q[i].data);
    end
    cycle();
    if (wr) golden[word] = wdata;
    if (!hit) begin
      res_valid[set] = 1'b1;
      res_line[set]  = line;
      res_dirty[set] = 1'b0;
    end
    if (wr) res_dirty[set] = 1'b1;
    read_en_i  = 1'b0;
    write_en_i = 1'b0;
    #1;
    check({tag, " idle_stall"}, 32'(stall_o), 32'h0);
    check({tag, " idle_read_data"}, read_data_o, 32'h0);
    $display("txn %s wr=%0d both=%0d addr=0x%08h stalls=%0d xfers=%0d", tag, wr, both, addr,
             stalls, seen_q.size());
  endtask

  initial begin
    int n;
    logic [31:0] a;
    bit wr, both;
    rst_i = 1'b0;
    read_en_i = 1'b0; write_en_i = 1'b0; addr_i = '0; write_data_i = '0;
    mem_rdata_i = '0; mem_ready_i = 1'b0;
    for (int s = 0; s < 16; s++) begin
      res_valid[s] = 1'b0; res_dirty[s] = 1'b0; res_line[s] = '0;
    end
    #2;
    check("reset mem_req", 32'(mem_req_o), 32'h0);
    check("reset mem_we", 32'(mem_we_o), 32'h0);
    check("reset mem_addr", mem_addr_o, 32'h0);
    check("reset mem_wdata", mem_wdata_o, 32'h0);
    check("reset stall", 32'(stall_o), 32'h0);
    check("reset read_data", read_data_o, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;

    access(0, 0, 32'h40, 32'h0, 1, "clean_miss_0x40");
    access(0, 0, 32'h48, 32'h0, 1, "hit_0x48");
    access(0, 0, 32'h4B, 32'h0, 1, "hit_low_bits_ignored");
    access(1, 0, 32'h44, 32'hDEADBEEF, 1, "write_hit_0x44");
    access(0, 0, 32'h144, 32'h0, 1, "dirty_miss_0x144");
    access(0, 0, 32'h280, 32'h0, 3, "slow_clean_miss_0x280");
    access(1, 1, 32'h148, 32'h12345678, 1, "both_high_hit_0x148");
    access(0, 0, 32'h48, 32'h0, 1, "evict_dirty_0x140_line");
    access(1, 0, 32'h50, 32'hCAFEF00D, 2, "store_miss_0x50");
    access(0, 0, 32'h50, 32'h0, 1, "read_back_0x50");

    for (int i = 0; i < 40; i++) begin
      a = {22'h0, 2'($urandom_range(0, 3)), 1'b0, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      wr   = 1'($urandom_range(0, 1));
      both = wr && ($urandom_range(0, 3) == 0);
      access(wr, both, a, $urandom, $urandom_range(1, 3), "random");
    end

    // Abort a refill in its second word with reset, then expect a full refill again.
    period = 1; req_cycles = 0; seen_q.delete();
    read_en_i = 1'b1; write_en_i = 1'b0; addr_i = 32'h3F0; write_data_i = '0;
    #1;
    n = 0;
    while (seen_q.size() < 1 && n < 50) begin
      n++;
      cycle();
    end
    check("pre_reset second word addr", mem_addr_o, 32'h3F4);
    check("pre_reset mem_req", 32'(mem_req_o), 32'h1);
    rst_i = 1'b0;
    #1;
    check("mid_reset mem_req", 32'(mem_req_o), 32'h0);
    check("mid_reset mem_addr", mem_addr_o, 32'h0);
    check("mid_reset mem_we", 32'(mem_we_o), 32'h0);
    read_en_i = 1'b0;
    #1;
    check("mid_reset stall", 32'(stall_o), 32'h0);
    check("mid_reset read_data", read_data_o, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int s = 0; s < 16; s++) begin
      res_valid[s] = 1'b0; res_dirty[s] = 1'b0;
    end
    golden = mainmem;
    #1;
    access(0, 0, 32'h3F0, 32'h0, 1, "post_reset_refill_0x3F0");
    access(0, 0, 32'h48, 32'h0, 1, "post_reset_miss_0x48");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
